// File: rtl/tone_reg_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tone_reg_scheduler: DDS master frame counter plus host write FIFO that    |
// | releases writes only inside the safe window. Optional: TONE_SCHED_OVF_FLAG_EN |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tone_reg_scheduler #(
   parameter int FRAME_LEN  = 1024,
   parameter int FIFO_DEPTH = 4,
   parameter int WIN_START  = 8
) (
   input  logic                          clk_in,
   input  logic                          reset_in,
   input  logic [15:0]                   wr_data_in,
   input  logic [3:0]                    wr_addr_in,
   input  logic                          wr_valid_in,
   output logic                          wr_ready_out,
   output logic [9:0]                    master_count_out,
   output logic                          frame_start_out,
   output logic [15:0]                   osc_data_out,
   output logic [3:0]                    osc_addr_out,
   output logic                          osc_valid_out,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out
`ifdef TONE_SCHED_OVF_FLAG_EN
   ,
   output logic                          ovf_flag_out
`endif
);

   localparam int         c_AW     = $clog2(FIFO_DEPTH);
   localparam int         c_LW     = c_AW + 1;
   localparam logic [9:0] c_LAST   = 10'(FRAME_LEN - 1);
   localparam logic [9:0] c_WIN_LO = 10'(WIN_START - 1);
   localparam logic [9:0] c_WIN_HI = 10'(FRAME_LEN - 3);
   localparam logic [c_LW-1:0] c_FULL = c_LW'(FIFO_DEPTH);

   logic [9:0]       r_count;
   logic [19:0]      r_mem [FIFO_DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_LW-1:0]  r_level;
   logic [15:0]      r_osc_data;
   logic [3:0]       r_osc_addr;
   logic             r_osc_valid;

   logic             w_ready;
   logic             w_push;
   logic             w_window;
   logic             w_pop;

   assign w_ready  = (r_level != c_FULL);
   assign w_push   = wr_valid_in && w_ready;
   // Pop one cycle early so the registered strobe lands inside [WIN_START, FRAME_LEN-2].
   assign w_window = (r_count >= c_WIN_LO) && (r_count <= c_WIN_HI);
   assign w_pop    = (r_level != '0) && w_window;

   always_ff @(posedge clk_in) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {wr_addr_in, wr_data_in};
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_count     <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_level     <= '0;
         r_osc_valid <= 1'b0;
         r_osc_data  <= '0;
         r_osc_addr  <= '0;
      end else begin
         r_count     <= (r_count == c_LAST) ? 10'd0 : r_count + 10'd1;
         r_osc_valid <= w_pop;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_osc_data <= r_mem[r_rd_ptr][15:0];
            r_osc_addr <= r_mem[r_rd_ptr][19:16];
         end
         if (w_push && !w_pop) begin
            r_level <= r_level + 1'b1;
         end else if (!w_push && w_pop) begin
            r_level <= r_level - 1'b1;
         end
      end
   end

`ifdef TONE_SCHED_OVF_FLAG_EN
   logic r_ovf;

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_ovf <= 1'b0;
      end else if (wr_valid_in && !w_ready) begin
         r_ovf <= 1'b1;
      end
   end

   assign ovf_flag_out = r_ovf;
`endif

   assign wr_ready_out     = w_ready;
   assign master_count_out = r_count;
   assign frame_start_out  = (r_count == 10'd0);
   assign osc_data_out     = r_osc_data;
   assign osc_addr_out     = r_osc_addr;
   assign osc_valid_out    = r_osc_valid;
   assign fifo_level_out   = r_level;

endmodule
`default_nettype wire

// File: doc/tone_reg_scheduler.md
Name: tone_reg_scheduler

Overview:
- Sequencer in front of the 4-voice DDS phase accumulator/mixer.
- Generates the 10-bit master frame count that drives the datapath's time-multiplexed accumulate/mix slots.
- Buffers host register writes (phase increment / volume) in a small FIFO and releases them to the datapath only inside a safe write window, outside the accumulate/mix slots (counts 0-7), so writes never collide with slot arithmetic.

Parameters:
- FRAME_LEN, 1024, master count period in clocks; legal 16..1024.
- FIFO_DEPTH, 4, host write FIFO entries; power of two, 2..16.
- WIN_START, 8, first master count at which a datapath write may be presented; must be >= 8 and <= FRAME_LEN-2.

Ports:
- clk_in  in  1  system clock
- reset_in  in  1  synchronous reset, active high
- wr_data_in  in  16  host write data
- wr_addr_in  in  4  host write address (passed through unchanged)
- wr_valid_in  in  1  host write request
- wr_ready_out  out  1  FIFO can accept a write this cycle
- master_count_out  out  10  frame count to datapath
- frame_start_out  out  1  high while master_count_out == 0
- osc_data_out  out  16  write data to datapath
- osc_addr_out  out  4  write address to datapath
- osc_valid_out  out  1  one-cycle write strobe to datapath
- fifo_level_out  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- One clock domain; all state updates on posedge clk_in.
- Reset, synchronous and active high:
  - master_count_out=0, osc_valid_out=0, osc_data_out=0, osc_addr_out=0.
  - FIFO emptied: fifo_level_out=0, wr_ready_out=1 from the first post-reset cycle.
  - Reset mid-operation discards all queued writes. No partial write is emitted.
- Master counter:
  - Increments by 1 every clock.
  - FRAME_LEN-1 wraps to 0. Upper bits are zero when FRAME_LEN < 1024.
  - frame_start_out is combinational (master_count_out == 0).
- Push:
  - A write is accepted when wr_valid_in && wr_ready_out.
  - wr_ready_out = (level != FIFO_DEPTH), derived from registered state only.
  - wr_valid_in while full: the write is not accepted. The host must hold it; nothing is dropped silently.
- Pop eligibility: FIFO non-empty AND master_count_out in [WIN_START-1, FRAME_LEN-3].
- Pop timing:
  - At most one pop per clock.
  - A popped entry is registered onto osc_*; osc_valid_out is high for exactly the following cycle.
  - Consequently osc_valid_out is only ever high while master_count_out is in [WIN_START, FRAME_LEN-2]. It is never high at counts 0..7 or FRAME_LEN-1.
  - osc_data_out and osc_addr_out hold their last value when osc_valid_out=0.
- Ordering and latency:
  - Strict FIFO order.
  - Minimum latency: push at count c (window open) gives osc_valid_out at count c+2.
- Simultaneous push and pop:
  - Level unchanged. Pointers both advance.
  - When full, ready is already 0, so there is no same-cycle bypass.
- Pointer wrap: pointers are modulo FIFO_DEPTH; level is tracked separately (0..FIFO_DEPTH).
- Burst drain: a burst larger than the remaining window drains at the next frame's WIN_START-1.

Optional Feature:
- Macro TONE_SCHED_OVF_FLAG_EN.
- Defined:
  - Adds output ovf_flag_out (1 bit), reset to 0.
  - Set sticky when wr_valid_in=1 and wr_ready_out=0 in the same cycle.
  - Cleared only by reset_in.
- Undefined: port absent; no extra logic.

Test Plan (FRAME_LEN=16, FIFO_DEPTH=4, WIN_START=8):
- Reset then run 40 clocks -> master_count_out 0..15,0..15,0..7; frame_start_out high exactly at cycles 0, 16, 32; osc_valid_out never high.
- Push {addr=1, data=0x1234} at count 9 -> osc_valid_out high only at count 11 with osc_addr_out=1, osc_data_out=0x1234; fifo_level_out back to 0.
- Push 4 writes at counts 0..3 -> fifo_level_out=4, wr_ready_out=0; outputs appear in order at counts 8, 9, 10, 11; wr_ready_out=1 again from count 8.
- Push 4 writes at count 12..15 -> at most counts 14 valid for the first popped entry (eligible only at count 13); remaining 3 held across the wrap and emitted at counts 8, 9, 10 of the next frame; nothing emitted at counts 15, 0..7.
- FIFO full, wr_valid_in held 3 cycles -> no level change, no data loss; with TONE_SCHED_OVF_FLAG_EN, ovf_flag_out=1 and stays 1 until reset.
- Reset asserted at count 9 with level=3 -> next cycle master_count_out=0, fifo_level_out=0, osc_valid_out=0; queued writes never appear.
